// File: rtl/video_pkg.sv
// Shared video timing constants and the port-scheduler state type.
package video_pkg;

  // 1280x720@60 raster
  localparam int DEF_ACTIVE_H_PIXELS = 1280;
  localparam int DEF_ACTIVE_LINES    = 720;
  localparam int DEF_TOTAL_PIXELS    = 1650;
  localparam int DEF_TOTAL_LINES     = 750;

  // Frame-buffer memory port
  localparam int DEF_PIX_PER_WORD    = 4;
  localparam int DEF_DATA_W          = 64;
  localparam int DEF_ADDR_W          = 18;
  localparam int DEF_MEM_LATENCY     = 2;
  localparam int DEF_WR_SLOT         = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fbs_state_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// Shift register of {valid, word index} that tracks memory reads in flight,
// so each returning word can be steered to its line-buffer slot.
module rd_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 9
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             issue_valid_in,
  input  logic [IDX_W-1:0] issue_idx_in,
  output logic             ret_valid_out,
  output logic [IDX_W-1:0] ret_idx_out
);

  logic             valid_reg [DEPTH];
  logic [IDX_W-1:0] idx_reg   [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             valid_d;
      logic [IDX_W-1:0] idx_d;

      if (gi == 0) begin : g_head
        assign valid_d = issue_valid_in;
        assign idx_d   = issue_idx_in;
      end else begin : g_body
        assign valid_d = valid_reg[gi-1];
        assign idx_d   = idx_reg[gi-1];
      end

      // Advance one stage per clock; a flush kills every read still in flight.
      always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in || flush_in) begin
          valid_reg[gi] <= 1'b0;
          idx_reg[gi]   <= '0;
        end else begin
          valid_reg[gi] <= valid_d;
          idx_reg[gi]   <= idx_d;
        end
      end
    end
  endgenerate

  assign ret_valid_out = valid_reg[DEPTH-1];
  assign ret_idx_out   = idx_reg[DEPTH-1];

endmodule

// File: rtl/fb_port_scheduler.sv
// Shares the single frame-buffer port between the display line prefetcher
// and one pixel writer. Each line start kicks off a fetch of the next
// displayed line into the idle line-buffer bank; the writer gets every
// WR_SLOT-th cycle during a fetch and the whole port otherwise.
module fb_port_scheduler
  import video_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
  parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
  parameter int TOTAL_PIXELS    = DEF_TOTAL_PIXELS,
  parameter int TOTAL_LINES     = DEF_TOTAL_LINES,
  parameter int PIX_PER_WORD    = DEF_PIX_PER_WORD,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
  parameter int WR_SLOT         = DEF_WR_SLOT,
  localparam int WORDS          = ACTIVE_H_PIXELS / PIX_PER_WORD,
  localparam int LB_AW          = $clog2(WORDS),
  localparam int H_W            = $clog2(TOTAL_PIXELS),
  localparam int V_W            = $clog2(TOTAL_LINES)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [H_W-1:0]    hcount_in,
  input  logic [V_W-1:0]    vcount_in,
  input  logic              wr_req_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_ack_out,
  output logic              mem_en_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              lb_we_out,
  output logic              lb_bank_out,
  output logic [LB_AW-1:0]  lb_waddr_out,
  output logic [DATA_W-1:0] lb_wdata_out,
  output logic              underrun_out
);

  localparam int SLOT_W = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;
  localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  fbs_state_t        state_reg, state_next;
  logic [LB_AW-1:0]  word_idx_reg, word_idx_next;
  logic [SLOT_W-1:0] slot_cnt_reg, slot_cnt_next;
  logic [LAT_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic              bank_reg, bank_next;
  logic [ADDR_W-1:0] line_base_reg, line_base_next;

  logic [V_W-1:0]    next_line;
  logic [ADDR_W-1:0] next_base;
  logic              line_start;
  logic              fetch_ok;
  logic              underrun;
  logic              grant_wr;
  logic              issue_rd;
  logic              act_wr;
  logic              act_rd;
  logic              ret_valid;
  logic [LB_AW-1:0]  ret_idx;

  // Line to prefetch: the one after the current line, wrapping at frame end.
  assign next_line  = (vcount_in == V_W'(TOTAL_LINES - 1)) ? '0 : vcount_in + 1'b1;
  assign next_base  = ADDR_W'(next_line) * ADDR_W'(WORDS);
  assign line_start = (hcount_in == '0);
  assign fetch_ok   = (next_line < V_W'(ACTIVE_LINES));
  assign underrun   = line_start && (state_reg != IDLE);

  // State and counter registers.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_reg     <= IDLE;
      word_idx_reg  <= '0;
      slot_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      bank_reg      <= 1'b0;
      line_base_reg <= '0;
    end else begin
      state_reg     <= state_next;
      word_idx_reg  <= word_idx_next;
      slot_cnt_reg  <= slot_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      bank_reg      <= bank_next;
      line_base_reg <= line_base_next;
    end
  end

  // Port arbitration and next-state; a line start always re-arms the fetch.
  always_comb begin
    state_next     = state_reg;
    word_idx_next  = word_idx_reg;
    slot_cnt_next  = slot_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    bank_next      = bank_reg;
    line_base_next = line_base_reg;
    grant_wr       = 1'b0;
    issue_rd       = 1'b0;

    case (state_reg)
      IDLE: begin
        grant_wr = wr_req_in;
      end
      FETCH: begin
        if (line_start) begin
          // Abandoned fetch: the port is free this cycle, so let the writer have it.
          grant_wr = wr_req_in;
        end else begin
          if ((slot_cnt_reg == SLOT_W'(WR_SLOT - 1)) && wr_req_in) begin
            grant_wr = 1'b1;
          end else begin
            issue_rd = 1'b1;
          end
          slot_cnt_next = (slot_cnt_reg == SLOT_W'(WR_SLOT - 1)) ? '0 : slot_cnt_reg + 1'b1;
          if (issue_rd) begin
            if (word_idx_reg == LB_AW'(WORDS - 1)) begin
              state_next     = DRAIN;
              drain_cnt_next = '0;
            end else begin
              word_idx_next = word_idx_reg + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        grant_wr = wr_req_in;
        if (drain_cnt_reg == LAT_W'(MEM_LATENCY - 1)) begin
          state_next = IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (line_start) begin
      if (fetch_ok) begin
        state_next     = FETCH;
        bank_next      = ~bank_reg;
        word_idx_next  = '0;
        slot_cnt_next  = '0;
        line_base_next = next_base;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Nothing reaches the memory or line buffer while reset is asserted.
  assign act_wr = rst_n_in && grant_wr;
  assign act_rd = rst_n_in && issue_rd;

  assign wr_ack_out    = act_wr;
  assign mem_en_out    = act_wr || act_rd;
  assign mem_we_out    = act_wr;
  assign mem_addr_out  = act_wr ? wr_addr_in :
                         act_rd ? (line_base_reg + ADDR_W'(word_idx_reg)) : '0;
  assign mem_wdata_out = act_wr ? wr_data_in : '0;
  assign underrun_out  = rst_n_in && underrun;
  assign lb_bank_out   = bank_reg;

  rd_valid_pipe #(
    .DEPTH (MEM_LATENCY),
    .IDX_W (LB_AW)
  ) u_rd_valid_pipe (
    .pixel_clk_in   (pixel_clk_in),
    .rst_n_in       (rst_n_in),
    .flush_in       (underrun),
    .issue_valid_in (act_rd),
    .issue_idx_in   (word_idx_reg),
    .ret_valid_out  (ret_valid),
    .ret_idx_out    (ret_idx)
  );

  // A word returning in the underrun cycle belongs to the abandoned line.
  assign lb_we_out    = rst_n_in && ret_valid && !underrun;
  assign lb_waddr_out = lb_we_out ? ret_idx : '0;
  assign lb_wdata_out = lb_we_out ? mem_rdata_in : '0;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Scoreboard bench for fb_port_scheduler: stimulus pushes expected memory
// and line-buffer traffic, a negedge monitor pops and compares.
module tb_fb_port_scheduler;
  import video_pkg::*;

  localparam int WORDS  = DEF_ACTIVE_H_PIXELS / DEF_PIX_PER_WORD;
  localparam int LB_AW  = $clog2(WORDS);
  localparam int H_W    = $clog2(DEF_TOTAL_PIXELS);
  localparam int V_W    = $clog2(DEF_TOTAL_LINES);
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DATA_W = DEF_DATA_W;
  localparam int LAT    = DEF_MEM_LATENCY;

  logic              pixel_clk_in = 1'b0;
  logic              rst_n_in;
  logic [H_W-1:0]    hcount_in;
  logic [V_W-1:0]    vcount_in;
  logic              wr_req_in;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              wr_ack_out;
  logic              mem_en_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [DATA_W-1:0] mem_rdata_in;
  logic              lb_we_out;
  logic              lb_bank_out;
  logic [LB_AW-1:0]  lb_waddr_out;
  logic [DATA_W-1:0] lb_wdata_out;
  logic              underrun_out;

  fb_port_scheduler dut (
    .pixel_clk_in  (pixel_clk_in),
    .rst_n_in      (rst_n_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .wr_req_in     (wr_req_in),
    .wr_addr_in    (wr_addr_in),
    .wr_data_in    (wr_data_in),
    .wr_ack_out    (wr_ack_out),
    .mem_en_out    (mem_en_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .lb_we_out     (lb_we_out),
    .lb_bank_out   (lb_bank_out),
    .lb_waddr_out  (lb_waddr_out),
    .lb_wdata_out  (lb_wdata_out),
    .underrun_out  (underrun_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_op_t;

  typedef struct {
    logic [LB_AW-1:0]  idx;
    logic [DATA_W-1:0] data;
  } lb_op_t;

  mem_op_t mem_q[$];
  lb_op_t  lb_q[$];

  int checks      = 0;
  int failures    = 0;
  int underrun_seen = 0;
  int wk          = 0;   // writer transaction counter driven onto the port
  int exp_k       = 0;   // writer transaction counter used for predictions
  logic exp_bank  = 1'b0;

  function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
    return {14'h155, a, 14'h2AA, a};
  endfunction

  function automatic logic [ADDR_W-1:0] wr_adr(input int k);
    return ADDR_W'(18'h30000 + k);
  endfunction

  function automatic logic [DATA_W-1:0] wr_pat(input int k);
    return {32'hD00D0000 + 32'(k), 32'h5A5A0000 + 32'(k)};
  endfunction

  function automatic int next_of(input int v);
    return (v == DEF_TOTAL_LINES - 1) ? 0 : v + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: read data appears LAT cycles after the read cycle.
  logic              cap_v;
  logic [ADDR_W-1:0] cap_a;
  logic              pv [LAT];
  logic [ADDR_W-1:0] pa [LAT];

  initial begin
    cap_v = 1'b0;
    cap_a = '0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
  end

  always @(negedge pixel_clk_in) begin
    cap_v = mem_en_out && !mem_we_out;
    cap_a = mem_addr_out;
  end

  always @(posedge pixel_clk_in) begin
    pv[0] <= cap_v;
    pa[0] <= cap_a;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign mem_rdata_in = pv[LAT-1] ? rd_pat(pa[LAT-1]) : '0;

  // Monitor: pop and compare on every memory access and line-buffer write.
  initial begin
    mem_op_t e;
    lb_op_t  l;
    forever begin
      @(negedge pixel_clk_in);
      chk("ack_is_write", wr_ack_out, mem_en_out & mem_we_out);
      if (mem_en_out) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected actual we=%0b addr=%0h required=no_access", mem_we_out, mem_addr_out);
        end else begin
          e = mem_q.pop_front();
          chk("mem_we", mem_we_out, e.we);
          chk("mem_addr", mem_addr_out, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata_out, e.data);
        end
      end
      if (lb_we_out) begin
        if (lb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL lb_unexpected actual idx=%0d required=no_write", lb_waddr_out);
        end else begin
          l = lb_q.pop_front();
          chk("lb_waddr", lb_waddr_out, l.idx);
          chk("lb_wdata", lb_wdata_out, l.data);
        end
      end
      if (underrun_out) underrun_seen++;
    end
  end

  task automatic push_fetch(input int v, input int nreads, input int nlb);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'(next_of(v) * WORDS);
    for (int i = 0; i < nreads; i++) mem_q.push_back('{1'b0, base + ADDR_W'(i), '0});
    for (int i = 0; i < nlb; i++) lb_q.push_back('{LB_AW'(i), rd_pat(base + ADDR_W'(i))});
  endtask

  task automatic push_write();
    mem_q.push_back('{1'b1, wr_adr(exp_k), wr_pat(exp_k)});
    exp_k++;
  endtask

  // Drive one line: hcount counts 0..len-1; optional writer window and reset window.
  task automatic run_line(input int v, input int len, input int wr_cycles,
                          input int rst_at, input int rst_len);
    logic ack;
    for (int c = 0; c < len; c++) begin
      hcount_in  = H_W'(c);
      vcount_in  = V_W'(v);
      wr_req_in  = (c < wr_cycles);
      wr_addr_in = wr_adr(wk);
      wr_data_in = wr_pat(wk);
      rst_n_in   = !(c >= rst_at && c < rst_at + rst_len && rst_at >= 0);
      if (!rst_n_in) exp_bank = 1'b0;
      else if (c == 0 && next_of(v) < DEF_ACTIVE_LINES) exp_bank = ~exp_bank;
      @(negedge pixel_clk_in);
      ack = wr_ack_out;
      if (c == 1) chk("lb_bank", lb_bank_out, exp_bank);
      @(posedge pixel_clk_in);
      #1;
      if (ack) wk++;
    end
    wr_req_in = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((mem_q.size() != 0 || lb_q.size() != 0) && n < 1000) begin
      @(posedge pixel_clk_in);
      n++;
    end
    chk("mem_q_drained", mem_q.size(), 0);
    chk("lb_q_drained", lb_q.size(), 0);
  endtask

  initial begin
    int reads;
    // Reset with the writer requesting: nothing may be granted.
    rst_n_in   = 1'b0;
    hcount_in  = H_W'(1);
    vcount_in  = '0;
    wr_req_in  = 1'b1;
    wr_addr_in = wr_adr(0);
    wr_data_in = wr_pat(0);
    @(posedge pixel_clk_in);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pixel_clk_in);
      chk("rst_wr_ack", wr_ack_out, 1'b0);
      chk("rst_mem_en", mem_en_out, 1'b0);
      chk("rst_mem_addr", mem_addr_out, '0);
      chk("rst_lb_we", lb_we_out, 1'b0);
      chk("rst_lb_bank", lb_bank_out, 1'b0);
      chk("rst_underrun", underrun_out, 1'b0);
      @(posedge pixel_clk_in);
      #1;
    end
    wr_req_in = 1'b0;
    rst_n_in  = 1'b1;
    hcount_in = H_W'(5);
    @(posedge pixel_clk_in);
    #1;

    // Plain fetch of line 10 (addresses 3200..3519).
    push_fetch(9, WORDS, WORDS);
    run_line(9, 340, 0, -1, 0);
    wait_empty();

    // Fetch with the writer always requesting: writes on every 4th fetch cycle.
    push_write();
    reads = 0;
    for (int f = 0; reads < WORDS; f++) begin
      if (f % DEF_WR_SLOT == DEF_WR_SLOT - 1) begin
        push_write();
      end else begin
        mem_q.push_back('{1'b0, ADDR_W'(11 * WORDS + reads), '0});
        lb_q.push_back('{LB_AW'(reads), rd_pat(ADDR_W'(11 * WORDS + reads))});
        reads++;
      end
    end
    run_line(10, 440, 427, -1, 0);
    wait_empty();

    // Frame wrap fetches line 0; last active line and blanking do not fetch.
    push_fetch(749, WORDS, WORDS);
    run_line(749, 340, 0, -1, 0);
    for (int i = 0; i < 8; i++) push_write();
    run_line(719, 20, 8, -1, 0);
    for (int i = 0; i < 8; i++) push_write();
    run_line(720, 20, 8, -1, 0);
    wait_empty();

    // Lines too short to finish: underrun each time, restart at word 0.
    underrun_seen = 0;
    for (int v = 30; v < 33; v++) begin
      push_fetch(v, 299, 297);
      run_line(v, 300, 0, -1, 0);
    end
    push_fetch(33, WORDS, WORDS);
    run_line(33, 340, 0, -1, 0);
    wait_empty();
    chk("underrun_count", underrun_seen, 3);

    // Reset in the middle of a fetch, then a normal line.
    push_fetch(40, 49, 47);
    run_line(40, 60, 0, 50, 2);
    push_fetch(41, WORDS, WORDS);
    run_line(41, 340, 0, -1, 0);
    wait_empty();
    chk("underrun_after_reset", underrun_seen, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
